// File: rtl/cnn_ctrl.sv
// Sequencer for one CNN output feature-map pass: clears the datapath, issues every
// (x,y) position in raster order, then waits for every accumulated result to come back.
module cnn_ctrl #(
   parameter int X_SIZE   = 16,
   parameter int Y_SIZE   = 16,
   parameter int PIPE_LAT = 4,
   parameter int CNT_BW   = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start_i,
   input  logic              stall_i,
   input  logic              acc_valid_i,
   output logic              soft_reset_o,
   output logic              issue_valid_o,
   output logic [7:0]        x_o,
   output logic [7:0]        y_o,
   output logic [CNT_BW-1:0] res_cnt_o,
   output logic              idle_o,
   output logic              done_o,
   output logic              err_o
);

   localparam int DW = $clog2(PIPE_LAT + 3);
   localparam logic [CNT_BW-1:0] TOTAL_C    = CNT_BW'(X_SIZE * Y_SIZE);
   localparam logic [CNT_BW-1:0] CNT_MAX    = {CNT_BW{1'b1}};
   localparam logic [CNT_BW-1:0] CNT_ONE    = CNT_BW'(1);
   localparam logic [DW-1:0]     DRAIN_ZERO = DW'(0);
   localparam logic [DW-1:0]     DRAIN_ONE  = DW'(1);
   localparam logic [DW-1:0]     DRAIN_LAST = DW'(PIPE_LAT + 1);
   localparam logic [7:0]        X_LAST     = 8'(X_SIZE - 1);
   localparam logic [7:0]        Y_LAST     = 8'(Y_SIZE - 1);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CLEAR = 3'd1,
      ST_RUN   = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   state_t            state_r, state_s;
   logic [DW-1:0]     drain_cnt_r, drain_cnt_s;
   logic              issue_s;
   logic [7:0]        x_s, y_s;
   logic [CNT_BW-1:0] cnt_s;
   logic              err_s;
   logic              acc_ok_s;

   // Next-state, position, result-count and error computation.
   always_comb begin
      state_s     = state_r;
      drain_cnt_s = drain_cnt_r;
      issue_s     = 1'b0;
      x_s         = x_o;
      y_s         = y_o;
      cnt_s       = res_cnt_o;
      err_s       = err_o;
      acc_ok_s    = ((state_r == ST_RUN) || (state_r == ST_DRAIN)) && (res_cnt_o != TOTAL_C);

      // A result outside the accepting window is an error and never counts.
      if (acc_valid_i) begin
         if (!acc_ok_s) begin
            err_s = 1'b1;
         end else if (res_cnt_o != CNT_MAX) begin
            cnt_s = res_cnt_o + CNT_ONE;
         end else begin
            cnt_s = res_cnt_o;
         end
      end else begin
         cnt_s = res_cnt_o;
      end

      case (state_r)
         ST_IDLE: begin
            if (start_i) begin
               state_s = ST_CLEAR;
               x_s     = 8'd0;
               y_s     = 8'd0;
               cnt_s   = {CNT_BW{1'b0}};
               err_s   = 1'b0;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_CLEAR: begin
            state_s     = ST_RUN;
            issue_s     = !stall_i;
            drain_cnt_s = DRAIN_ZERO;
         end
         ST_RUN: begin
            // Position only moves once the currently presented one has been issued.
            if (issue_valid_o) begin
               if ((x_o == X_LAST) && (y_o == Y_LAST)) begin
                  state_s     = ST_DRAIN;
                  issue_s     = 1'b0;
                  drain_cnt_s = DRAIN_ZERO;
               end else if (x_o == X_LAST) begin
                  x_s     = 8'd0;
                  y_s     = y_o + 8'd1;
                  issue_s = !stall_i;
               end else begin
                  x_s     = x_o + 8'd1;
                  issue_s = !stall_i;
               end
            end else begin
               issue_s = !stall_i;
            end
         end
         ST_DRAIN: begin
            if (res_cnt_o == TOTAL_C) begin
               state_s = ST_DONE;
            end else if (drain_cnt_r == DRAIN_LAST) begin
               state_s = ST_DONE;
               err_s   = 1'b1;
            end else begin
               drain_cnt_s = drain_cnt_r + DRAIN_ONE;
            end
         end
         ST_DONE: begin
            state_s = ST_IDLE;
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // State and registered outputs; reset never pulses soft_reset_o.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r       <= ST_IDLE;
         drain_cnt_r   <= DRAIN_ZERO;
         soft_reset_o  <= 1'b0;
         issue_valid_o <= 1'b0;
         x_o           <= 8'd0;
         y_o           <= 8'd0;
         res_cnt_o     <= {CNT_BW{1'b0}};
         idle_o        <= 1'b1;
         done_o        <= 1'b0;
         err_o         <= 1'b0;
      end else begin
         state_r       <= state_s;
         drain_cnt_r   <= drain_cnt_s;
         soft_reset_o  <= (state_s == ST_CLEAR);
         issue_valid_o <= issue_s;
         x_o           <= x_s;
         y_o           <= y_s;
         res_cnt_o     <= cnt_s;
         idle_o        <= (state_s == ST_IDLE);
         done_o        <= (state_s == ST_DONE);
         err_o         <= err_s;
      end
   end

endmodule

// File: doc/cnn_ctrl.md
CNN_CTRL -- requirements
Module: cnn_ctrl

Interface
REQ-001 SHALL have parameter X_SIZE, default 16: output feature-map width in positions (range 1..255).
REQ-002 SHALL have parameter Y_SIZE, default 16: output feature-map height in positions (range 1..255).
REQ-003 SHALL have parameter PIPE_LAT, default 4: maximum cycles from issue_valid_o to the matching acc_valid_i from the CI-accumulation datapath.
REQ-004 SHALL have parameter CNT_BW, default 16: width of the result counter.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port start_i, input, 1 bit: single-cycle pulse that begins one feature-map pass.
REQ-008 SHALL have port stall_i, input, 1 bit: holds issue while high.
REQ-009 SHALL have port acc_valid_i, input, 1 bit: result-valid strobe from the datapath.
REQ-010 SHALL have port soft_reset_o, output, 1 bit: clears the datapath pipeline.
REQ-011 SHALL have port issue_valid_o, output, 1 bit: drives the datapath input-valid.
REQ-012 SHALL have port x_o, output, 8 bits: column of the current issue.
REQ-013 SHALL have port y_o, output, 8 bits: row of the current issue.
REQ-014 SHALL have port res_cnt_o, output, CNT_BW bits: results received in this pass.
REQ-015 SHALL have port idle_o, output, 1 bit: high in the IDLE state.
REQ-016 SHALL have port done_o, output, 1 bit: one-cycle pulse at the end of a pass.
REQ-017 SHALL have port err_o, output, 1 bit: sticky error flag.

Function
REQ-018 SHALL implement FSM states IDLE, CLEAR, RUN, DRAIN and DONE, with all outputs registered.
REQ-019 In IDLE, start_i=1 SHALL go to CLEAR; start_i SHALL be ignored in all other states.
REQ-020 Entering CLEAR SHALL clear res_cnt_o, x_o, y_o and err_o.
REQ-021 CLEAR SHALL last exactly 1 cycle with soft_reset_o=1, then go to RUN; soft_reset_o SHALL be 0 in every other state.
REQ-022 In RUN with stall_i=0, issue_valid_o SHALL be 1 and (x_o,y_o) SHALL present the current position.
REQ-023 After each issue, x_o SHALL advance by 1; at X_SIZE-1 it SHALL wrap to 0 and y_o SHALL advance by 1.
REQ-024 In RUN with stall_i=1, issue_valid_o SHALL be 0 and x_o/y_o SHALL hold.
REQ-025 The first issue SHALL occur on the cycle after CLEAR, when stall_i=0.
REQ-026 Issuing position (X_SIZE-1, Y_SIZE-1) SHALL move the FSM to DRAIN on the next cycle, with issue_valid_o=0 from then on; total issues SHALL equal X_SIZE*Y_SIZE.
REQ-027 Each cycle acc_valid_i=1 in RUN or DRAIN SHALL increment res_cnt_o by 1, saturating at all-ones.
REQ-028 In DRAIN, the cycle after res_cnt_o reaches X_SIZE*Y_SIZE SHALL go to DONE.
REQ-029 DRAIN SHALL run a cycle counter; if the count reaches PIPE_LAT+2 without completion, the FSM SHALL set err_o=1 and go to DONE.
REQ-030 acc_valid_i=1 when res_cnt_o already equals X_SIZE*Y_SIZE, or while in IDLE/CLEAR/DONE, SHALL set err_o=1 and SHALL NOT increment res_cnt_o.
REQ-031 err_o SHALL stay set until reset or the next CLEAR.
REQ-032 DONE SHALL last 1 cycle with done_o=1, then go to IDLE.
REQ-033 res_cnt_o SHALL hold its final value in IDLE until the next start.
REQ-034 When stall_i and acc_valid_i occur in the same cycle, both SHALL be honoured independently: issue holds, count increments.

Reset
REQ-035 reset=1 SHALL force IDLE on the next edge from any state, including mid-RUN or mid-DRAIN, and SHALL take priority over start_i.
REQ-036 Reset values: idle_o=1; soft_reset_o, issue_valid_o, done_o and err_o all 0; x_o, y_o and res_cnt_o all 0.
REQ-037 A reset SHALL NOT assert soft_reset_o; datapath clearing occurs only via CLEAR.

Verification
REQ-038 Use X_SIZE=3, Y_SIZE=2, PIPE_LAT=4 with a 4-cycle delayed echo of issue_valid_o on acc_valid_i; pulse start -> soft_reset_o for 1 cycle, then 6 consecutive issues (0,0),(1,0),(2,0),(0,1),(1,1),(2,1), done_o 1 cycle after the 6th result, res_cnt_o=6, err_o=0.
REQ-039 Same setup, stall_i high for 3 cycles after the 2nd issue -> exactly 6 issues with none repeated or skipped, and the positions hold during the stall.
REQ-040 Drop the last echoed acc_valid_i -> err_o=1 after 6 DRAIN cycles, done_o pulses, res_cnt_o=5.
REQ-041 Inject an extra acc_valid_i after 6 results, or one while in IDLE -> err_o=1 and res_cnt_o unchanged.
REQ-042 Assert reset mid-RUN -> next cycle idle_o=1 and all outputs at reset values; a subsequent start completes a clean pass.
REQ-043 Pulse start_i during RUN -> ignored, and the pass completes normally.
